output_byte: RTL and testbench

- Downstream neighbour of the 64-bit block collector; consumes 64-bit 3DES result blocks and serializes them into bytes for the I2C slave or the SRAM interface.
- One block is buffered in a holding register and one is in the shift register, so the DES core can hand over the next block while the current one drains.
- Byte order matches the collector's: MSB byte [63:56] goes first, and the first byte received ends up in the MSB on the input side.

---
 rtl/des_pkg.sv | 13 +
 rtl/output_byte.sv | 117 +++++++++++
 tb/tb_output_byte.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Constants and state encoding shared by the 3DES byte collector and serializer.
package des_pkg;

    localparam int BLOCK_W = 64;
    localparam int BYTE_W  = 8;
    localparam int NBYTES  = 8;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/output_byte.sv
// Serializes 64-bit 3DES result blocks into bytes, MSB byte first, towards I2C or SRAM.
// A holding register lets the next block be accepted while the current one drains.
module output_byte #(
    parameter int NBYTES = 8,
    parameter int BYTE_W = 8
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       dir_sel,
    input  logic [NBYTES*BYTE_W-1:0]   block_in,
    input  logic                       block_valid,
    output logic                       block_accept,
    output logic [BYTE_W-1:0]          to_i2c,
    output logic [BYTE_W-1:0]          to_sram,
    output logic                       i2c_valid,
    output logic                       sram_valid,
    input  logic                       byte_ack,
    output logic                       busy,
    output logic                       block_done
);
    import des_pkg::*;

    localparam int BLOCK_W = NBYTES * BYTE_W;
    localparam int CNT_W   = $clog2(NBYTES);

    logic [BLOCK_W-1:0] r_hold;
    logic [BLOCK_W-1:0] r_shift;
    logic               r_hold_full;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir;
    logic               r_block_done;
    state_t             r_state;
    state_t             w_state_nxt;

    logic               w_accept;
    logic               w_last;
    logic               w_load;
    logic               w_shift_en;
    logic               w_done;
    logic               w_send;
    logic [BYTE_W-1:0]  w_byte;

    assign w_accept = block_valid & ~r_hold_full;
    assign w_last   = (r_cnt == CNT_W'(NBYTES - 1));

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (byte_ack) begin
                    if (!w_last) begin
                        w_shift_en = 1'b1;
                    end else begin
                        w_done = 1'b1;
                        // A waiting block reloads here so its first byte follows without a gap.
                        if (r_hold_full) w_load = 1'b1;
                        else             w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: data registers are cleared too, so a reset leaves no stale block behind.
            r_state      <= IDLE;
            r_hold       <= '0;
            r_shift      <= '0;
            r_hold_full  <= 1'b0;
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_block_done <= w_done;
            if (w_accept) begin
                r_hold      <= block_in;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_load) begin
                r_shift <= r_hold;
                r_dir   <= dir_sel;
                r_cnt   <= '0;
            end else if (w_shift_en) begin
                r_shift <= r_shift << BYTE_W;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_send = (r_state == SEND);
    assign w_byte = r_shift[BLOCK_W-1 -: BYTE_W];

    assign block_accept = ~r_hold_full;
    assign busy         = w_send | r_hold_full;
    assign block_done   = r_block_done;
    assign i2c_valid    = w_send & ~r_dir;
    assign sram_valid   = w_send & r_dir;
    assign to_i2c       = (w_send && !r_dir) ? w_byte : '0;
    assign to_sram      = (w_send &&  r_dir) ? w_byte : '0;

endmodule

// File: tb/tb_output_byte.sv
// Scoreboard bench for output_byte: expected bytes are queued when a block is offered
// and compared as each byte is acknowledged.
module tb_output_byte;

    logic        clk;
    logic        nrst;
    logic        dir_sel;
    logic [63:0] block_in;
    logic        block_valid;
    logic        block_accept;
    logic [7:0]  to_i2c;
    logic [7:0]  to_sram;
    logic        i2c_valid;
    logic        sram_valid;
    logic        byte_ack;
    logic        busy;
    logic        block_done;

    typedef struct packed {
        logic       dir;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_done = 0;

    output_byte #(.NBYTES(8), .BYTE_W(8)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .dir_sel      (dir_sel),
        .block_in     (block_in),
        .block_valid  (block_valid),
        .block_accept (block_accept),
        .to_i2c       (to_i2c),
        .to_sram      (to_sram),
        .i2c_valid    (i2c_valid),
        .sram_valid   (sram_valid),
        .byte_ack     (byte_ack),
        .busy         (busy),
        .block_done   (block_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer side: every acknowledged byte is compared against the queue head,
    // including the requirement that the unselected output reads 00.
    always @(negedge clk) begin
        if (nrst && block_done) n_done++;
        if (nrst && byte_ack && (i2c_valid || sram_valid)) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL byte_unexpected: got i2c=%h sram=%h, expected no byte", to_i2c, to_sram);
            end else begin
                mon_e = sb.pop_front();
                if ((i2c_valid && sram_valid) || (sram_valid !== mon_e.dir) ||
                    ({to_i2c, to_sram} !== (mon_e.dir ? {8'h00, mon_e.data} : {mon_e.data, 8'h00})))
                    $display("FAIL byte_stream: got i2c=%h/%b sram=%h/%b, expected dir=%b byte=%h",
                             to_i2c, i2c_valid, to_sram, sram_valid, mon_e.dir, mon_e.data);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_block(input logic [63:0] blk, input logic dir);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.dir  = dir;
            e.data = blk[63-8*i -: 8];
            sb.push_back(e);
        end
    endtask

    task automatic offer(input logic [63:0] blk, input logic dir);
        int t = 0;
        @(posedge clk); #1;
        block_in    = blk;
        dir_sel     = dir;
        block_valid = 1'b1;
        push_block(blk, dir);
        @(negedge clk);
        while (!block_accept && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!block_accept) begin
            n_total++;
            $display("FAIL offer_timeout: block_accept=%b, expected 1", block_accept);
        end
        @(posedge clk); #1;
        block_valid = 1'b0;
    endtask

    task automatic wait_valid(input logic dir);
        int t = 0;
        @(negedge clk);
        while (!(dir ? sram_valid : i2c_valid) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!(dir ? sram_valid : i2c_valid)) begin
            n_total++;
            $display("FAIL valid_timeout: valid never rose for dir=%b", dir);
        end
    endtask

    task automatic drain();
        int t = 0;
        @(posedge clk); #1;
        byte_ack = 1'b1;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        byte_ack = 1'b0;
        n_total++;
        if (busy !== 1'b0 || sb.size() != 0)
            $display("FAIL drain: busy=%b pending=%0d, expected busy=0 pending=0", busy, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        nrst = 1'b0; dir_sel = 1'b0; block_in = '0; block_valid = 1'b0; byte_ack = 1'b0;
        #12;
        n_total++;
        if ({to_i2c, to_sram, i2c_valid, sram_valid, busy, block_done} !== 20'h0 || block_accept !== 1'b1)
            $display("FAIL reset_state: outs=%h accept=%b, expected outs=0 accept=1",
                     {to_i2c, to_sram, i2c_valid, sram_valid, busy, block_done}, block_accept);
        else
            n_pass++;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_single_i2c();
        int d0 = n_done;
        int i2c_cnt = 0;
        int sram_cnt = 0;
        offer(64'h0123456789ABCDEF, 1'b0);
        @(posedge clk); #1;
        byte_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i2c_valid)  i2c_cnt++;
            if (sram_valid) sram_cnt++;
        end
        byte_ack = 1'b0;
        n_total++;
        if (i2c_cnt != 8) $display("FAIL single_i2c_valid_cycles: got %0d, expected 8", i2c_cnt);
        else n_pass++;
        n_total++;
        if (sram_cnt != 0) $display("FAIL single_sram_valid: got %0d cycles, expected 0", sram_cnt);
        else n_pass++;
        n_total++;
        if (n_done - d0 != 1) $display("FAIL single_done_pulses: got %0d, expected 1", n_done - d0);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || sb.size() != 0)
            $display("FAIL single_idle_after: busy=%b pending=%0d, expected 0/0", busy, sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int d0 = n_done;
        offer(64'h0123456789ABCDEF, 1'b1);
        wait_valid(1'b1);
        @(posedge clk); #1;
        byte_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 byte_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (to_sram !== 8'h45 || sram_valid !== 1'b1)
                $display("FAIL stall_hold: got to_sram=%h valid=%b, expected 45/1", to_sram, sram_valid);
            else n_pass++;
        end
        drain();
        n_total++;
        if (n_done - d0 != 1) $display("FAIL stall_done_pulses: got %0d, expected 1", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0 = n_done;
        int gaps = 0;
        offer({8{8'h11}}, 1'b0);
        offer({8{8'h22}}, 1'b0);
        @(negedge clk);
        n_total++;
        if (block_accept !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_accept_drop: accept=%b busy=%b, expected 0/1", block_accept, busy);
        else n_pass++;
        @(posedge clk); #1;
        byte_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!i2c_valid) gaps++;
        end
        n_total++;
        if (gaps != 0) $display("FAIL b2b_gap: got %0d idle cycles, expected 0", gaps);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (i2c_valid !== 1'b0 || block_done !== 1'b1)
            $display("FAIL b2b_end: valid=%b done=%b, expected 0/1", i2c_valid, block_done);
        else n_pass++;
        byte_ack = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (n_done - d0 != 2 || sb.size() != 0)
            $display("FAIL b2b_done_pulses: got %0d pending=%0d, expected 2/0", n_done - d0, sb.size());
        else n_pass++;
    endtask

    task automatic test_dir_switch();
        int d0 = n_done;
        offer(64'hA0A1A2A3A4A5A6A7, 1'b0);
        wait_valid(1'b0);
        offer(64'hB0B1B2B3B4B5B6B7, 1'b1);
        drain();
        n_total++;
        if (n_done - d0 != 2) $display("FAIL dir_switch_done: got %0d, expected 2", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        int bad = 0;
        offer(64'hC0C1C2C3C4C5C6C7, 1'b0);
        wait_valid(1'b0);
        offer(64'hD0D1D2D3D4D5D6D7, 1'b0);
        @(posedge clk); #1;
        byte_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 byte_ack = 1'b0;
        d0 = n_done;
        @(negedge clk); #2;
        nrst = 1'b0;
        #1;
        n_total++;
        if ({to_i2c, to_sram, i2c_valid, sram_valid, busy, block_done} !== 20'h0 || block_accept !== 1'b1)
            $display("FAIL reset_mid_outputs: outs=%h accept=%b, expected outs=0 accept=1",
                     {to_i2c, to_sram, i2c_valid, sram_valid, busy, block_done}, block_accept);
        else n_pass++;
        repeat (2) @(negedge clk);
        sb.delete();
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (block_done || busy) bad++;
        end
        n_total++;
        if (bad != 0 || n_done != d0)
            $display("FAIL reset_mid_no_done: bad=%0d pulses=%0d, expected 0/0", bad, n_done - d0);
        else n_pass++;
        offer(64'hFEDCBA9876543210, 1'b1);
        drain();
        n_total++;
        if (n_done - d0 != 1) $display("FAIL reset_mid_fresh_done: got %0d, expected 1", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_spurious_ack();
        int d0 = n_done;
        int bad = 0;
        @(posedge clk); #1;
        byte_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || i2c_valid || sram_valid || !block_accept) bad++;
        end
        byte_ack = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (bad != 0 || n_done != d0)
            $display("FAIL spurious_ack: bad=%0d pulses=%0d, expected 0/0", bad, n_done - d0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_i2c();
        test_backpressure();
        test_back_to_back();
        test_dir_switch();
        test_reset_mid();
        test_spurious_ack();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
